// File: rtl/seg14_pkg.sv
// Shared definitions for the 14-segment message path: character codes, the
// font table and the message-source FSM encoding.
//
// Glyph bit order, MSB first: a b c d e f g1 g2 h i j k l m
//   a..f   outer segments (top, upper-right, lower-right, bottom, lower-left, upper-left)
//   g1/g2  left/right middle bars
//   h i j  upper-left diagonal, upper vertical, upper-right diagonal
//   k l m  lower-left diagonal, lower vertical, lower-right diagonal
package seg14_pkg;

  localparam logic [5:0] CH_SPACE = 6'd0;
  localparam logic [5:0] CH_A     = 6'd1;
  localparam logic [5:0] CH_Z     = 6'd26;
  localparam logic [5:0] CH_ENYE  = 6'd27;
  localparam logic [5:0] CH_0     = 6'd28;
  localparam logic [5:0] CH_9     = 6'd37;

  localparam int unsigned FontEntries = 38;

  // Indexed directly by character code; codes above CH_9 render blank.
  localparam logic [13:0] FONT_TABLE [FontEntries] = '{
    14'b00000000000000,  // space
    14'b11101111000000,  // A
    14'b11110001010010,  // B
    14'b10011100000000,  // C
    14'b11110000010010,  // D
    14'b10011110000000,  // E
    14'b10001110000000,  // F
    14'b10111101000000,  // G
    14'b01101111000000,  // H
    14'b10010000010010,  // I
    14'b01111000000000,  // J
    14'b00001110001001,  // K
    14'b00011100000000,  // L
    14'b01101100101000,  // M
    14'b01101100100001,  // N
    14'b11111100000000,  // O
    14'b11001111000000,  // P
    14'b11111100000001,  // Q
    14'b11001111000001,  // R
    14'b10110111000000,  // S
    14'b10000000010010,  // T
    14'b01111100000000,  // U
    14'b00001100001100,  // V
    14'b01101100000101,  // W
    14'b00000000101101,  // X
    14'b00000000101010,  // Y
    14'b10010000001100,  // Z
    14'b11101100100001,  // N-tilde (N with top bar as tilde)
    14'b11111100001100,  // 0
    14'b01100000001000,  // 1
    14'b11011011000000,  // 2
    14'b11110001000000,  // 3
    14'b01100111000000,  // 4
    14'b10010110000001,  // 5
    14'b10111111000000,  // 6
    14'b11100000000000,  // 7
    14'b11111111000000,  // 8
    14'b11110111000000   // 9
  };

  typedef enum logic [1:0] {
    StBlank,
    StRun,
    StPause
  } msg_state_e;

endpackage

// File: rtl/seg14_font_rom.sv
// Combinational character-code to 14-segment glyph lookup.
// Ports:
//   code   6-bit character code
//   glyph  14-bit segment pattern (0 for codes outside the font)
module seg14_font_rom
  import seg14_pkg::*;
(
  input  logic [5:0]  code,
  output logic [13:0] glyph
);

  always_comb begin
    glyph = '0;
    if (code <= CH_9) begin
      glyph = FONT_TABLE[code];
    end
  end

endmodule

// File: rtl/seg14_msg_source.sv
// Message buffer and scroller feeding the 14-segment scan stage.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   wr_valid/wr_ready   character write handshake into the message buffer
//   wr_addr, wr_char    buffer index and character code to write
//   len_load, len_val   latch a new message length (restarts scrolling)
//   scroll_en           1 = scroll, 0 = freeze
//   digit_idx           digit currently scanned
//   glyph               registered segment pattern for digit_idx
//   wrap_pulse          one-cycle pulse when the scroll offset wraps to 0
module seg14_msg_source
  import seg14_pkg::*;
#(
  parameter int unsigned         DIGITS     = 12,
  parameter int unsigned         MSG_DEPTH  = 32,
  parameter int unsigned         SCROLL_W   = 24,
  parameter logic [SCROLL_W-1:0] SCROLL_DIV = 24'd6_000_000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [$clog2(MSG_DEPTH)-1:0] wr_addr,
  input  logic [5:0]                   wr_char,
  input  logic                         len_load,
  input  logic [$clog2(MSG_DEPTH):0]   len_val,
  input  logic                         scroll_en,
  input  logic [$clog2(DIGITS)-1:0]    digit_idx,
  output logic [13:0]                  glyph,
  output logic                         wrap_pulse
);

  localparam int unsigned         AW        = $clog2(MSG_DEPTH);
  localparam int unsigned         LW        = AW + 1;
  localparam int unsigned         SW        = LW + 1;
  localparam logic [SCROLL_W-1:0] PrescLast = SCROLL_DIV - SCROLL_W'(1);
  localparam logic [LW-1:0]       DepthLen  = LW'(MSG_DEPTH);

  msg_state_e          state_q, state_d;
  logic [LW-1:0]       len_q, len_d;
  logic [AW-1:0]       offset_q, offset_d;
  logic [SCROLL_W-1:0] presc_q, presc_d;
  logic [13:0]         glyph_q, glyph_d;
  logic                wrap_q, wrap_d;
  logic                live_q;
  logic [5:0]          buf_q [MSG_DEPTH];

  logic          scrolling, counting, terminal, step, wr_fire, wraps, blank_pos;
  logic [LW-1:0] off_plus;
  logic [SW-1:0] idx_sum, idx_wrapped;
  logic [AW-1:0] rd_idx;
  logic [13:0]   rom_glyph;

  // Only messages longer than the display scroll; shorter ones sit static at offset 0.
  assign scrolling = 32'(len_q) > DIGITS;
  // PAUSE with scroll_en high counts too, so a resumed count picks up exactly where it froze.
  assign counting  = (state_q != StBlank) && scroll_en && !len_load;
  assign terminal  = presc_q == PrescLast;
  assign step      = counting && terminal && scrolling;
  // live_q keeps writes blocked for the first cycle after reset.
  assign wr_ready  = live_q && !step;
  assign wr_fire   = wr_valid && wr_ready;
  assign off_plus  = LW'(offset_q) + LW'(1);
  assign wraps     = off_plus == len_q;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    offset_d = offset_q;
    presc_d  = presc_q;
    wrap_d   = 1'b0;
    if (len_load) begin
      len_d    = (len_val > DepthLen) ? DepthLen : len_val;
      offset_d = '0;
      presc_d  = '0;
      state_d  = (len_val == '0) ? StBlank : StRun;
    end else begin
      unique case (state_q)
        StBlank: ;
        StRun:   if (!scroll_en) state_d = StPause;
        StPause: if (scroll_en) state_d = StRun;
        default: ;
      endcase
      if (counting) begin
        presc_d = terminal ? '0 : presc_q + SCROLL_W'(1);
        if (step) begin
          offset_d = wraps ? '0 : AW'(off_plus);
          wrap_d   = wraps;
        end
      end
    end
  end

  // offset < len and digit_idx < DIGITS, so one conditional subtract gives the modulo.
  assign idx_sum     = SW'(offset_q) + SW'(digit_idx);
  assign idx_wrapped = (idx_sum >= SW'(len_q)) ? idx_sum - SW'(len_q) : idx_sum;
  assign rd_idx      = AW'(idx_wrapped);

  seg14_font_rom u_font (
    .code  (buf_q[rd_idx]),
    .glyph (rom_glyph)
  );

  assign blank_pos = (state_q == StBlank) || (32'(digit_idx) >= DIGITS) ||
                     (!scrolling && (LW'(digit_idx) >= len_q));

  always_comb begin
    glyph_d = rom_glyph;
    if (blank_pos) begin
      glyph_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StBlank;
      len_q    <= '0;
      offset_q <= '0;
      presc_q  <= '0;
      glyph_q  <= '0;
      wrap_q   <= 1'b0;
      live_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      offset_q <= offset_d;
      presc_q  <= presc_d;
      glyph_q  <= glyph_d;
      wrap_q   <= wrap_d;
      live_q   <= 1'b1;
    end
  end

  // Buffer contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      buf_q[wr_addr] <= wr_char;
    end
  end

  assign glyph      = glyph_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_seg14_msg_source.sv
module tb_seg14_msg_source;

  localparam int DIGITS    = 12;
  localparam int MSG_DEPTH = 32;
  localparam int DIV       = 4;

  logic        clk = 1'b0;
  logic        rst_n, wr_valid, wr_ready, len_load, scroll_en, wrap_pulse;
  logic [4:0]  wr_addr;
  logic [5:0]  wr_char, len_val;
  logic [3:0]  digit_idx;
  logic [13:0] glyph;

  always #5 clk = ~clk;

  seg14_msg_source #(
    .DIGITS     (12),
    .MSG_DEPTH  (32),
    .SCROLL_W   (24),
    .SCROLL_DIV (24'd4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_char    (wr_char),
    .len_load   (len_load),
    .len_val    (len_val),
    .scroll_en  (scroll_en),
    .digit_idx  (digit_idx),
    .glyph      (glyph),
    .wrap_pulse (wrap_pulse)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: message length, scroll position, cycles into the current step.
  int          m_len, m_off, m_cnt;
  bit          m_live, m_ready, m_step, m_wrap, m_accept;
  int          m_buf [MSG_DEPTH];
  logic [13:0] m_glyph;
  int          n_wrap, n_busy;
  logic        last_ready;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [13:0] ref_font(input int code);
    case (code)
      0:  return 14'b00000000000000;
      1:  return 14'b11101111000000;
      2:  return 14'b11110001010010;
      3:  return 14'b10011100000000;
      4:  return 14'b11110000010010;
      5:  return 14'b10011110000000;
      6:  return 14'b10001110000000;
      7:  return 14'b10111101000000;
      8:  return 14'b01101111000000;
      9:  return 14'b10010000010010;
      10: return 14'b01111000000000;
      11: return 14'b00001110001001;
      12: return 14'b00011100000000;
      13: return 14'b01101100101000;
      14: return 14'b01101100100001;
      15: return 14'b11111100000000;
      16: return 14'b11001111000000;
      17: return 14'b11111100000001;
      18: return 14'b11001111000001;
      19: return 14'b10110111000000;
      20: return 14'b10000000010010;
      21: return 14'b01111100000000;
      22: return 14'b00001100001100;
      23: return 14'b01101100000101;
      24: return 14'b00000000101101;
      25: return 14'b00000000101010;
      26: return 14'b10010000001100;
      27: return 14'b11101100100001;
      28: return 14'b11111100001100;
      29: return 14'b01100000001000;
      30: return 14'b11011011000000;
      31: return 14'b11110001000000;
      32: return 14'b01100111000000;
      33: return 14'b10010110000001;
      34: return 14'b10111111000000;
      35: return 14'b11100000000000;
      36: return 14'b11111111000000;
      37: return 14'b11110111000000;
      default: return 14'b0;
    endcase
  endfunction

  // Called at a negedge with inputs already driven; returns at the following negedge.
  task automatic cycle();
    bit active;
    int di;
    #1;
    di         = int'(digit_idx);
    active     = (m_len != 0) && scroll_en && !len_load;
    m_step     = active && (m_cnt == DIV - 1) && (m_len > DIGITS);
    m_ready    = m_live && !m_step;
    last_ready = wr_ready;
    if (!wr_ready) n_busy++;
    check_eq("wr_ready", 32'(wr_ready), 32'(m_ready));
    if (!rst_n || m_len == 0 || di >= DIGITS || (m_len <= DIGITS && di >= m_len))
      m_glyph = 14'b0;
    else
      m_glyph = ref_font(m_buf[(m_off + di) % m_len]);
    m_wrap   = 1'b0;
    m_accept = 1'b0;
    if (!rst_n) begin
      m_len = 0; m_off = 0; m_cnt = 0; m_live = 1'b0;
    end else begin
      m_live = 1'b1;
      if (wr_valid && m_ready) begin
        m_buf[int'(wr_addr)] = int'(wr_char);
        m_accept = 1'b1;
      end
      if (len_load) begin
        m_len = (int'(len_val) > MSG_DEPTH) ? MSG_DEPTH : int'(len_val);
        m_off = 0;
        m_cnt = 0;
      end else if (active) begin
        if (m_cnt == DIV - 1) begin
          m_cnt = 0;
          if (m_len > DIGITS) begin
            m_off  = (m_off + 1) % m_len;
            m_wrap = (m_off == 0);
          end
        end else begin
          m_cnt++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (wrap_pulse === 1'b1) n_wrap++;
    check_eq("glyph", 32'(glyph), 32'(m_glyph));
    check_eq("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
  endtask

  task automatic write_char(input int addr, input int ch);
    wr_valid = 1'b1;
    wr_addr  = 5'(addr);
    wr_char  = 6'(ch);
    m_accept = 1'b0;
    for (int t = 0; t < 16 && !m_accept; t++) cycle();
    check_eq("wr_accept", 32'(m_accept), 32'd1);
    wr_valid = 1'b0;
  endtask

  task automatic load_len(input int len);
    len_load = 1'b1;
    len_val  = 6'(len);
    cycle();
    len_load = 1'b0;
  endtask

  task automatic wait_cnt(input int target);
    for (int t = 0; t < 8 && m_cnt != target; t++) cycle();
  endtask

  initial begin
    int pussy [5];
    int spaces [14];
    int nc, addr;
    pussy  = '{16, 21, 19, 19, 25};
    spaces = '{19, 16, 1, 3, 5, 19, 0, 0, 0, 0, 0, 0, 0, 0};
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_char = '0;
    len_load = 1'b0; len_val = '0; scroll_en = 1'b0; digit_idx = '0;
    m_len = 0; m_off = 0; m_cnt = 0; m_live = 1'b0;
    n_wrap = 0; n_busy = 0;
    for (int i = 0; i < MSG_DEPTH; i++) m_buf[i] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_glyph", 32'(glyph), 32'd0);
    check_eq("rst_wrap", 32'(wrap_pulse), 32'd0);
    check_eq("rst_ready", 32'(wr_ready), 32'd0);
    cycle();
    rst_n = 1'b1;
    cycle();

    // Fill the whole buffer so every read in the model is defined.
    for (int a = 0; a < MSG_DEPTH; a++) write_char(a, int'($urandom_range(0, 63)));

    // Static message, shorter than the display.
    for (int a = 0; a < 5; a++) write_char(a, pussy[a]);
    load_len(5);
    scroll_en = 1'b1;
    n_wrap = 0;
    for (int i = 0; i < DIGITS; i++) begin
      digit_idx = 4'(i);
      cycle();
      if (i == 0) check_eq("pussy_idx0", 32'(glyph), 32'(14'b11001111000000));
      if (i == 2) check_eq("pussy_idx2", 32'(glyph), 32'(14'b10110111000000));
      if (i >= 5) check_eq("pussy_blank", 32'(glyph), 32'd0);
    end
    check_eq("pussy_nowrap", 32'(n_wrap), 32'd0);

    // Scrolling message of 14: one full revolution.
    for (int a = 0; a < 14; a++) write_char(a, spaces[a]);
    load_len(14);
    n_wrap = 0;
    n_busy = 0;
    for (int k = 1; k <= 58; k++) begin
      digit_idx = (k == 5) ? 4'd0 : 4'($urandom_range(0, 11));
      cycle();
      if (k == 5) check_eq("scroll_first", 32'(glyph), 32'(14'b11001111000000));
    end
    check_eq("wrap_count", 32'(n_wrap), 32'd1);
    check_eq("busy_count", 32'(n_busy), 32'd14);

    // Freeze two cycles into a step, then resume.
    scroll_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      digit_idx = 4'($urandom_range(0, 11));
      cycle();
    end
    scroll_en = 1'b1;
    cycle();
    check_eq("resume_hold", 32'(last_ready), 32'd1);
    cycle();
    check_eq("resume_step", 32'(last_ready), 32'd0);

    // Write held across a step cycle, targeting the digit-0 position after the step.
    digit_idx = 4'd0;
    wait_cnt(DIV - 1);
    addr = (m_off + 1) % m_len;
    nc = int'($urandom_range(1, 37));
    if (nc == m_buf[addr]) nc = nc % 37 + 1;
    write_char(addr, nc);
    cycle();
    check_eq("wr_visible", 32'(glyph), 32'(ref_font(nc)));

    // len_load colliding with the terminal count.
    wait_cnt(DIV - 1);
    digit_idx = 4'($urandom_range(0, 11));
    load_len(20);
    check_eq("ll_ready", 32'(last_ready), 32'd1);
    check_eq("ll_nowrap", 32'(wrap_pulse), 32'd0);
    digit_idx = 4'd0;
    cycle();
    check_eq("ll_idx0", 32'(glyph), 32'(ref_font(m_buf[0])));

    // Zero length blanks every digit.
    load_len(0);
    for (int i = 0; i < DIGITS; i++) begin
      digit_idx = 4'(i);
      cycle();
      check_eq("blank_glyph", 32'(glyph), 32'd0);
    end

    // Reset while scrolling at offset 7.
    load_len(20);
    for (int t = 0; t < 400 && m_off != 7; t++) begin
      digit_idx = 4'($urandom_range(0, 11));
      cycle();
    end
    rst_n = 1'b0;
    cycle();
    check_eq("rst_mid_glyph", 32'(glyph), 32'd0);
    check_eq("rst_mid_ready", 32'(wr_ready), 32'd0);
    check_eq("rst_mid_wrap", 32'(wrap_pulse), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      digit_idx = 4'($urandom_range(0, 11));
      cycle();
      check_eq("post_rst_blank", 32'(glyph), 32'd0);
    end

    // Random traffic, including out-of-range digits, saturating lengths and rare resets.
    for (int k = 0; k < 3000; k++) begin
      rst_n     = ($urandom_range(0, 499) != 0);
      len_load  = rst_n && ($urandom_range(0, 39) == 0);
      len_val   = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(10, 20))
                                              : 6'($urandom_range(0, 63));
      scroll_en = ($urandom_range(0, 9) != 0);
      wr_valid  = rst_n && ($urandom_range(0, 3) == 0);
      wr_addr   = 5'($urandom_range(0, 31));
      wr_char   = 6'($urandom_range(0, 63));
      digit_idx = 4'($urandom_range(0, 15));
      cycle();
    end
    rst_n = 1'b1; len_load = 1'b0; wr_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/seg14_msg_source.md
Name: seg14_msg_source

Overview:
- Upstream feeder for the 12-digit 14-segment scan stage.
- Holds a writable message of up to MSG_DEPTH 6-bit character codes and scrolls it across the 12 digits at a programmable rate.
- Returns the 14-bit glyph for whichever digit index the scan stage's counter presents. This replaces the hard-wired glyph registers in the scanner with a loadable, scrolling message.

Parameters:
- DIGITS, 12, number of display positions; digit_idx values 0..DIGITS-1 are valid.
- MSG_DEPTH, 32, character buffer entries; power of two.
- SCROLL_W, 24, width of the scroll prescaler.
- SCROLL_DIV, 24'd6_000_000, clk cycles per one-character scroll step; must be >= 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_valid  in  1  character write request.
- wr_ready  out  1  buffer accepts a write this cycle.
- wr_addr  in  5  buffer index ($clog2(MSG_DEPTH)).
- wr_char  in  6  character code.
- len_load  in  1  pulse; latch len_val as the message length.
- len_val  in  6  message length, 0..MSG_DEPTH; values above MSG_DEPTH saturate to MSG_DEPTH.
- scroll_en  in  1  level; 1 = scrolling runs, 0 = frozen.
- digit_idx  in  4  digit currently being scanned (driven by the scan counter).
- glyph  out  14  segment pattern for digit_idx, registered.
- wrap_pulse  out  1  one-cycle pulse when the scroll offset wraps to 0.

Behaviour:
- Reset (rst_n=0 at posedge):
  - glyph=0, wrap_pulse=0, wr_ready=0.
  - len=0, offset=0, prescaler=0.
  - state=ST_BLANK.
  - Buffer contents are not reset.
- Character codes:
  - 0 = space.
  - 1..26 = A..Z.
  - 27 = Ñ.
  - 28..37 = digits 0..9.
  - 38..63 = blank (glyph 0).
- Write handshake:
  - A write happens when wr_valid && wr_ready at posedge; the buffer is updated the next cycle.
  - wr_ready=1 in every state except the single cycle in which a scroll step is applied.
  - A write to an index currently on display becomes visible one cycle after the write.
- len_load:
  - Sets len, clears offset and prescaler.
  - Has priority over a scroll step in the same cycle.
  - A simultaneous write still completes.
- FSM:
  - ST_BLANK: entered when len==0; glyph forced to 0. Goes to ST_RUN on len_load with len_val!=0.
  - ST_RUN: prescaler counts 0..SCROLL_DIV-1. At terminal count it applies a step only when len>DIGITS: offset <= (offset+1==len) ? 0 : offset+1, and wrap_pulse=1 when offset returns to 0. If scroll_en=0, go to ST_PAUSE.
  - ST_PAUSE: prescaler and offset hold, glyph continues tracking digit_idx. Returns to ST_RUN when scroll_en=1, resuming the count where it stopped.
  - From any state, len_load with len_val==0 goes to ST_BLANK.
- Static mode:
  - When len<=DIGITS, offset is held at 0 and no wrap_pulse is produced.
  - Positions with digit_idx>=len show blank.
- Glyph path (1-cycle latency):
  - Message index = (offset+digit_idx) mod len, computed by a single conditional subtract. Valid because offset<len and digit_idx<DIGITS<=MSG_DEPTH; if needed, use two conditional subtracts.
  - glyph <= font(buffer[index]).
  - If digit_idx>=DIGITS, glyph <= 0.
- Reset mid-scroll: everything returns to reset values on that edge; no wrap_pulse is produced.

Decomposition:
- Package seg14_pkg holds:
  - Character-code localparams (CH_SPACE=0, CH_A=1 .. CH_0=28).
  - The 14-bit font constants, e.g. A=14'b11101111000000, S=14'b10110111000000, P=14'b11001111000000, T=14'b10000000010010, E=14'b10011110000000.
  - State encoding.
- Sub-module seg14_font_rom: purely combinational code-to-glyph lookup. Shared with later display blocks.

Test Plan:
- Reset, then write codes "PUSSY" (P=16, U=21, S=19, S=19, Y=25) at addresses 0..4, len_load 5, sweep digit_idx 0..11 -> glyph for idx0 = 14'b11001111000000 one cycle after each idx; idx2 = 14'b10110111000000; idx5..11 = 0. No wrap_pulse.
- SCROLL_DIV=4, len=14 ("SPACES" padding), scroll_en=1 -> offset advances every 4 cycles. The digit_idx=0 glyph shows buffer[1] after the first step. wrap_pulse fires exactly once after 14 steps. wr_ready is low only in the step cycles.
- scroll_en drops mid-count for 10 cycles -> offset frozen. The step occurs 4 - elapsed cycles after re-enable.
- Write to the displayed index (addr=offset) with wr_valid held -> accepted when wr_ready=1. The new glyph appears on the following scan of that digit.
- len_load on the same cycle as a scroll terminal count -> offset=0, no step, no wrap_pulse. len_load 0 -> all glyphs 0.
- Pulse rst_n low while scrolling at offset 7 -> next cycle glyph=0, wr_ready=0, len=0. After release, the block stays in ST_BLANK until len_load.
